// File: rtl/dma_job_scheduler.sv
// DMA job scheduler: buffers (start address, length) jobs and runs them one at a time
// through the partition engine, acknowledging each done and aggregating errors/interrupts.
module dma_job_scheduler #(
   parameter int JOB_D     = 4,
   parameter int JOB_W     = $clog2(JOB_D + 1),
   parameter int AXI_BYTES = 16,
   parameter int TO_W      = 16,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [31:0]      job_sa,
   input  logic [31:0]      job_len,
   output logic             cfg_dma_valid,
   input  logic             cfg_dma_ready,
   output logic [31:0]      cfg_dma_sa,
   output logic [31:0]      cfg_dma_len,
   input  logic             dma_irq,
   input  logic [3:0]       dma_err,
   output logic             dma_irq_w1c,
   input  logic [TO_W-1:0]  sch_timeout_cyc,
   output logic             sch_irq,
   input  logic             sch_irq_w1c,
   output logic [3:0]       sch_err,
   output logic [CNT_W-1:0] sch_done_cnt,
   output logic [JOB_W-1:0] sch_pend,
   output logic             sch_busy,
   output logic [2:0]       dbg_state
);

   // Handshakes (job_* and cfg_dma_*): a transfer happens on a rising clk edge where
   // valid and ready are both 1; valid and its payload stay stable until that edge.

   localparam int          PTR_W   = (JOB_D > 1) ? $clog2(JOB_D) : 1;
   localparam logic [31:0] MIN_LEN = AXI_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACK   = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [JOB_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        sa_mem_q  [JOB_D];
   logic [31:0]        sa_mem_d  [JOB_D];
   logic [31:0]        len_mem_q [JOB_D];
   logic [31:0]        len_mem_d [JOB_D];
   logic               ready_q, ready_d;
   logic [TO_W-1:0]    timer_q, timer_d;
   logic [3:0]         err_q, err_d;
   logic               irq_q, irq_d;
   logic               fail_q, fail_d;
   logic [CNT_W-1:0]   done_q, done_d;

   logic               push;
   logic               pop;
   logic               empty;
   logic               set_irq;
   logic [3:0]         set_err;
   logic [31:0]        head_sa;
   logic [31:0]        head_len;
   logic               unused_err3;

   assign unused_err3 = dma_err[3];
   assign head_sa     = sa_mem_q[rd_ptr_q];
   assign head_len    = len_mem_q[rd_ptr_q];
   assign empty       = (cnt_q == '0);
   assign push        = job_valid && ready_q;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      sa_mem_d  = sa_mem_q;
      len_mem_d = len_mem_q;
      timer_d   = timer_q;
      fail_d    = fail_q;
      done_d    = done_q;
      pop       = 1'b0;
      set_irq   = 1'b0;
      set_err   = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               // Jobs shorter than one bus beat are retired without touching the engine.
               if (head_len < MIN_LEN) begin
                  pop    = 1'b1;
                  done_d = done_q + CNT_W'(1);
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (cfg_dma_ready) begin
               pop     = 1'b1;
               timer_d = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timer_q != '1) begin
               timer_d = timer_q + TO_W'(1);
            end
            // Timeout only flags the job; the engine is left to finish on its own.
            if ((sch_timeout_cyc != '0) && (timer_q == sch_timeout_cyc - TO_W'(1))) begin
               set_err[3] = 1'b1;
            end
            if (dma_irq) begin
               set_err[2:0] = dma_err[2:0];
               fail_d       = |dma_err[2:0];
               state_d      = ST_ACK;
            end
         end
         ST_ACK: begin
            done_d = done_q + CNT_W'(1);
            if (fail_q) begin
               set_irq = 1'b1;
               state_d = ST_HALT;
            end else begin
               set_irq = empty;
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (sch_irq_w1c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (push) begin
         sa_mem_d[wr_ptr_q]  = job_sa;
         len_mem_d[wr_ptr_q] = job_len;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + JOB_W'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - JOB_W'(1);
      end
      ready_d = (cnt_d != JOB_W'(JOB_D));

      // A clear and a new set in the same cycle: the set survives.
      irq_d = (irq_q && !sch_irq_w1c) || set_irq;
      err_d = (sch_irq_w1c ? 4'b0000 : err_q) | set_err;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         timer_q  <= '0;
         err_q    <= 4'b0000;
         irq_q    <= 1'b0;
         fail_q   <= 1'b0;
         done_q   <= '0;
         for (int i = 0; i < JOB_D; i++) begin
            sa_mem_q[i]  <= '0;
            len_mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         irq_q     <= irq_d;
         fail_q    <= fail_d;
         done_q    <= done_d;
         sa_mem_q  <= sa_mem_d;
         len_mem_q <= len_mem_d;
      end
   end

   assign job_ready     = ready_q;
   assign cfg_dma_valid = (state_q == ST_ISSUE);
   assign cfg_dma_sa    = cfg_dma_valid ? head_sa : 32'd0;
   assign cfg_dma_len   = cfg_dma_valid ? head_len : 32'd0;
   assign dma_irq_w1c   = (state_q == ST_ACK);
   assign sch_irq       = irq_q;
   assign sch_err       = err_q;
   assign sch_done_cnt  = done_q;
   assign sch_pend      = cnt_q;
   assign sch_busy      = (state_q != ST_IDLE) || !empty;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Bench for dma_job_scheduler: engine model, issue scoreboard, directed scenarios and
// randomized batches checked against a job-list reference model.
module tb_dma_job_scheduler;
  localparam int JOB_D = 4;
  localparam int JOB_W = 3;
  localparam int AXI_BYTES = 16;
  localparam int TO_W = 16;
  localparam int CNT_W = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HALT = 3'd4;

  logic clk = 1'b0;
  logic reset_n;
  logic job_valid, job_ready;
  logic [31:0] job_sa, job_len;
  logic cfg_dma_valid, cfg_dma_ready;
  logic [31:0] cfg_dma_sa, cfg_dma_len;
  logic dma_irq;
  logic [3:0] dma_err;
  logic dma_irq_w1c;
  logic [TO_W-1:0] sch_timeout_cyc;
  logic sch_irq, sch_irq_w1c;
  logic [3:0] sch_err;
  logic [CNT_W-1:0] sch_done_cnt;
  logic [JOB_W-1:0] sch_pend;
  logic sch_busy;
  logic [2:0] dbg_state;

  dma_job_scheduler #(
    .JOB_D(JOB_D), .JOB_W(JOB_W), .AXI_BYTES(AXI_BYTES), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_sa(job_sa), .job_len(job_len),
    .cfg_dma_valid(cfg_dma_valid), .cfg_dma_ready(cfg_dma_ready),
    .cfg_dma_sa(cfg_dma_sa), .cfg_dma_len(cfg_dma_len),
    .dma_irq(dma_irq), .dma_err(dma_err), .dma_irq_w1c(dma_irq_w1c),
    .sch_timeout_cyc(sch_timeout_cyc), .sch_irq(sch_irq), .sch_irq_w1c(sch_irq_w1c),
    .sch_err(sch_err), .sch_done_cnt(sch_done_cnt), .sch_pend(sch_pend),
    .sch_busy(sch_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];        // expected issue order {sa, len}
  logic [3:0] plan_err_q[$];    // engine response per issued job
  int plan_dly_q[$];
  bit eng_hold = 1'b0;
  int rst_gen = 0;
  int w1c_cnt = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [31:0] sa, input logic [31:0] len,
                          input logic [3:0] err, input int dly);
    int k;
    k = 0;
    job_valid = 1'b1;
    job_sa = sa;
    job_len = len;
    while (!job_ready && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) chk("push_ready_timeout", 1, 0);
    if (len >= AXI_BYTES) begin
      exp_q.push_back({sa, len});
      plan_err_q.push_back(err);
      plan_dly_q.push_back(dly);
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic irq_clear();
    @(posedge clk); #1;
    sch_irq_w1c = 1'b1;
    @(posedge clk); #1;
    sch_irq_w1c = 1'b0;
  endtask

  task automatic wait_done(input bit want_halt);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 3000) begin
      @(negedge clk);
      k++;
      hit = want_halt ? (dbg_state == S_HALT) : !sch_busy;
    end
    chk(want_halt ? "wait_halt" : "wait_idle", hit, 1);
  endtask

  // ---------------- engine model ----------------
  initial begin : engine
    int r, d, g, k;
    logic [3:0] e;
    cfg_dma_ready = 1'b0;
    dma_irq = 1'b0;
    dma_err = 4'd0;
    forever begin
      @(negedge clk);
      if (reset_n && cfg_dma_valid && !eng_hold) begin
        g = rst_gen;
        r = $urandom_range(0, 2);
        @(posedge clk);
        repeat (r) @(posedge clk);
        #1;
        if (rst_gen == g) begin
          cfg_dma_ready = 1'b1;
          @(posedge clk); #1;
          cfg_dma_ready = 1'b0;
          if (plan_err_q.size() > 0) begin
            e = plan_err_q.pop_front();
            d = plan_dly_q.pop_front();
          end else begin
            e = 4'd0;
            d = 0;
          end
          for (int i = 0; i < d && rst_gen == g; i++) @(posedge clk);
          if (d > 0) #1;
          if (rst_gen == g) begin
            dma_irq = 1'b1;
            dma_err = e;
            k = 0;
            while (rst_gen == g && !dma_irq_w1c && k < 300) begin
              @(negedge clk);
              k++;
            end
            if (k >= 300) chk("engine_w1c_timeout", 1, 0);
            @(posedge clk); #1;
          end
          dma_irq = 1'b0;
          dma_err = 4'd0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [63:0] e;
    logic w1c_prev;
    w1c_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (cfg_dma_valid && cfg_dma_ready) begin
          if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("issue_job", {cfg_dma_sa, cfg_dma_len}, e);
          end
        end
        if (dma_irq_w1c) begin
          w1c_cnt++;
          chk("w1c_single_cycle", w1c_prev, 0);
        end
      end
      w1c_prev = dma_irq_w1c;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, {job_ready, cfg_dma_valid, cfg_dma_sa, cfg_dma_len, dma_irq_w1c,
                         sch_irq, sch_err, sch_done_cnt, sch_pend, sch_busy}, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int base, n, i, k;
    bit early, fail, last_issued;
    logic [3:0] seg_err;
    logic [31:0] lens[4];
    logic [31:0] sas[4];
    logic [3:0] errs[4];
    int dlys[4];

    reset_n = 1'b0;
    job_valid = 1'b0; job_sa = '0; job_len = '0;
    sch_timeout_cyc = '0; sch_irq_w1c = 1'b0;
    cyc(3);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", job_ready, 0);
    @(negedge clk);
    chk("ready_after_release", job_ready, 1);

    // Single job: latency, values, completion
    cyc(1);
    base = w1c_cnt;
    push_job(32'h1000, 32'h400, 4'd0, 3);
    @(negedge clk);
    chk("lat_t1_valid", cfg_dma_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", cfg_dma_valid, 1);
    chk("lat_t2_payload", {cfg_dma_sa, cfg_dma_len}, {32'h1000, 32'h400});
    wait_done(0);
    exp_done += 1;
    chk("single_done", sch_done_cnt, 64'(exp_done % 65536));
    chk("single_irq", sch_irq, 1);
    chk("single_err", sch_err, 0);
    chk("single_w1c_count", w1c_cnt - base, 1);
    irq_clear();
    @(negedge clk);
    chk("irq_cleared", sch_irq, 0);

    // Fill the queue while the engine stalls, then drain in order
    eng_hold = 1'b1;
    base = w1c_cnt;
    for (int j = 0; j < 4; j++) push_job(32'h8000 + 32'(j) * 32'h100, 32'h40 + 32'(j), 4'd0, j);
    @(negedge clk);
    chk("full_ready", job_ready, 0);
    chk("full_pend", sch_pend, 4);
    eng_hold = 1'b0;
    early = 1'b0;
    k = 0;
    while (sch_busy && k < 3000) begin
      @(negedge clk);
      k++;
      if (sch_irq && (w1c_cnt - base) < 4) early = 1'b1;
    end
    chk("batch4_drained", sch_busy, 0);
    chk("batch4_irq_early", early, 0);
    exp_done += 4;
    chk("batch4_irq", sch_irq, 1);
    chk("batch4_done", sch_done_cnt, 64'(exp_done % 65536));
    chk("batch4_w1c_count", w1c_cnt - base, 4);
    irq_clear();

    // Error on job 2 of 3 halts the scheduler
    push_job(32'h4000, 32'h80, 4'd0, 2);
    push_job(32'h4100, 32'h200, 4'b0010, 1);
    push_job(32'h4200, 32'h20, 4'd0, 1);
    wait_done(1);
    exp_done += 2;
    chk("halt_irq", sch_irq, 1);
    chk("halt_err", sch_err, 4'b0010);
    chk("halt_pend", sch_pend, 1);
    chk("halt_done", sch_done_cnt, 64'(exp_done % 65536));
    cyc(3);
    @(negedge clk);
    chk("halt_no_issue", {dbg_state, cfg_dma_valid}, {S_HALT, 1'b0});
    irq_clear();
    wait_done(0);
    exp_done += 1;
    chk("resume_err", sch_err, 0);
    chk("resume_irq", sch_irq, 1);
    chk("resume_done", sch_done_cnt, 64'(exp_done % 65536));
    irq_clear();

    // Short job is retired without engine traffic
    cyc(1);
    push_job(32'h3000, 32'd8, 4'd0, 0);
    push_job(32'h3100, 32'h100, 4'd0, 2);
    @(negedge clk);
    exp_done += 1;
    chk("skip_done_next", sch_done_cnt, 64'(exp_done % 65536));
    wait_done(0);
    exp_done += 1;
    chk("skip_then_issue_done", sch_done_cnt, 64'(exp_done % 65536));
    chk("skip_then_issue_irq", sch_irq, 1);
    irq_clear();

    // Timeout flag on the tenth WAIT cycle
    sch_timeout_cyc = 16'd10;
    push_job(32'h2000, 32'h40, 4'd0, 20);
    k = 0;
    while (!(cfg_dma_valid && cfg_dma_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("to_handshake_seen", k < 100, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("to_before", sch_err[3], 0);
    @(negedge clk);
    chk("to_at_10", sch_err[3], 1);
    wait_done(0);
    exp_done += 1;
    chk("to_err_final", sch_err, 4'b1000);
    chk("to_irq", sch_irq, 1);
    chk("to_done", sch_done_cnt, 64'(exp_done % 65536));
    irq_clear();
    @(negedge clk);
    chk("to_cleared", {sch_irq, sch_err}, 0);
    sch_timeout_cyc = '0;

    // Randomized batches against the job-list model
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        sas[j]  = $urandom;
        lens[j] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(16, 4096));
        errs[j] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        dlys[j] = $urandom_range(0, 6);
      end
      for (int j = 0; j < n; j++) begin
        push_job(sas[j], lens[j], errs[j], dlys[j]);
        cyc($urandom_range(0, 2));
      end
      last_issued = (lens[n-1] >= AXI_BYTES);
      i = 0;
      while (i < n) begin
        seg_err = 4'd0;
        fail = 1'b0;
        while (i < n && !fail) begin
          exp_done++;
          if (lens[i] >= AXI_BYTES) begin
            seg_err |= {1'b0, errs[i][2:0]};
            if (errs[i][2:0] != 3'd0) fail = 1'b1;
          end
          i++;
        end
        wait_done(fail);
        chk("rnd_done", sch_done_cnt, 64'(exp_done % 65536));
        chk("rnd_err", sch_err, seg_err);
        if (fail) begin
          chk("rnd_halt_irq", sch_irq, 1);
          chk("rnd_halt_pend", sch_pend, n - i);
          irq_clear();
        end else if (last_issued) begin
          chk("rnd_batch_irq", sch_irq, 1);
        end
      end
      irq_clear();
      @(negedge clk);
      chk("rnd_cleared", {sch_irq, sch_err}, 0);
    end
    chk("rnd_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a job with two queued behind it
    push_job(32'h5000, 32'h100, 4'd0, 100);
    push_job(32'h5100, 32'h100, 4'd0, 1);
    push_job(32'h5200, 32'h100, 4'd0, 1);
    k = 0;
    while (dbg_state != S_WAIT && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_wait_state", dbg_state, S_WAIT);
    chk("mid_wait_pend", sch_pend, 2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    rst_gen++;
    exp_q.delete();
    plan_err_q.delete();
    plan_dly_q.delete();
    #1;
    chk_all_zero("async_reset");
    cyc(2);
    @(negedge clk);
    chk_all_zero("held_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_ready", job_ready, 1);
    chk("post_reset_idle", {dbg_state, sch_pend, sch_busy, sch_done_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
